// File: rtl/and3_rr_sched_if.sv
// rtl/and3_rr_sched_if.sv - request/grant and response channel bundle for and3_rr_sched
interface and3_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] ops;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2:0]        rsp_x;
  logic              rsp_z;
  logic              busy;

  modport master (
    output req, ops, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_x, rsp_z, busy
  );

  modport slave (
    input  req, ops, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_x, rsp_z, busy
  );
endinterface

// File: rtl/and3_rr_sched.sv
// rtl/and3_rr_sched.sv - round-robin scheduler sharing one registered 3-input AND; AND3_RR_SCHED_STATS_EN adds handshake counters
module and3_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  and3_rr_sched_if.slave bus
`ifdef AND3_RR_SCHED_STATS_EN
  ,
  output logic [15:0]    cnt_eval,
  output logic [15:0]    cnt_true
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [IDW-1:0] id_q, id_d;
  logic [2:0]     op_q, op_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [2:0]     rsp_x_q, rsp_x_d;
  logic           rsp_z_q, rsp_z_d;

  logic           any_req;
  logic [IDW-1:0] win_id;
  logic [2:0]     win_op;
  logic           hs;

  // Rotating search: the nearest requester after last_id wins; scanning
  // the offsets from far to near lets the nearest one overwrite the rest.
  always_comb begin
    int idx;
    any_req = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_id_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[IDW'(idx)]) begin
        any_req = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_id) win_op = bus.ops[3*i +: 3];
    end
  end

  // Grant is only offered while idle; captured on the same edge.
  always_comb begin
    bus.gnt = '0;
    if (state_q == IDLE && any_req) bus.gnt[win_id] = 1'b1;
  end

  assign hs = (state_q == RESP) && bus.rsp_ready;

  // Next-state and datapath capture; response registers only change when
  // entering RESP so they hold their last values everywhere else.
  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    id_d      = id_q;
    op_d      = op_q;
    rsp_id_d  = rsp_id_q;
    rsp_x_d   = rsp_x_q;
    rsp_z_d   = rsp_z_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          op_d      = win_op;
          id_d      = win_id;
          last_id_d = win_id;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        rsp_id_d = id_q;
        rsp_x_d  = op_q;
        rsp_z_d  = &op_q;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; pointer resets so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_id_q <= IDW'(NREQ - 1);
      id_q      <= '0;
      op_q      <= '0;
      rsp_id_q  <= '0;
      rsp_x_q   <= '0;
      rsp_z_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      id_q      <= id_d;
      op_q      <= op_d;
      rsp_id_q  <= rsp_id_d;
      rsp_x_q   <= rsp_x_d;
      rsp_z_q   <= rsp_z_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_x     = rsp_x_q;
  assign bus.rsp_z     = rsp_z_q;

`ifdef AND3_RR_SCHED_STATS_EN
  logic [15:0] cnt_eval_q, cnt_eval_d;
  logic [15:0] cnt_true_q, cnt_true_d;

  // Saturating handshake counters.
  always_comb begin
    cnt_eval_d = cnt_eval_q;
    cnt_true_d = cnt_true_q;
    if (hs) begin
      if (cnt_eval_q != 16'hFFFF) cnt_eval_d = cnt_eval_q + 16'd1;
      if (rsp_z_q && cnt_true_q != 16'hFFFF) cnt_true_d = cnt_true_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_eval_q <= '0;
      cnt_true_q <= '0;
    end else begin
      cnt_eval_q <= cnt_eval_d;
      cnt_true_q <= cnt_true_d;
    end
  end

  assign cnt_eval = cnt_eval_q;
  assign cnt_true = cnt_true_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_and3_rr_sched.sv
// tb/tb_and3_rr_sched.sv - self-checking bench for and3_rr_sched against a transaction-level model
module tb_and3_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  int   model_last;
  int   last_gnt;
  int   hs_cyc;
  int   exp_eval;
  int   exp_true;

  and3_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef AND3_RR_SCHED_STATS_EN
  logic [15:0] cnt_eval;
  logic [15:0] cnt_true;
  and3_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_eval(cnt_eval), .cnt_true(cnt_true)
  );
`else
  and3_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Spec rule: nearest set request after the last winner, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    bus.req = '0;
    bus.ops = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = NREQ - 1;
    exp_eval = 0;
    exp_true = 0;
  endtask

  // One full transaction driven from IDLE, checked cycle by cycle.
  task automatic do_txn(input logic [NREQ-1:0] r, input logic [3*NREQ-1:0] o, input int dly);
    int w;
    int gcyc;
    logic [2:0] x;
    logic [NREQ-1:0] exp_g;
    bus.req = r;
    bus.ops = o;
    bus.rsp_ready = 1'($urandom_range(0, 1));
    w = pick(r, model_last);
    exp_g = (w < 0) ? '0 : (NREQ'(1) << w);
    @(negedge clk);
    checks++;
    if (bus.gnt !== exp_g) begin
      errors++; $display("FAIL gnt: got %b expected %b", bus.gnt, exp_g);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_flags: valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
    end
    gcyc = cyc;
    @(posedge clk); #1;
    last_gnt = w;
    if (w < 0) return;
    x = o[3*w +: 3];
    model_last = w;
    bus.req = NREQ'($urandom);
    bus.ops = (3*NREQ)'($urandom);
    bus.rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.gnt !== '0) begin
      errors++; $display("FAIL eval: valid=%b busy=%b gnt=%b expected 0 1 0", bus.rsp_valid, bus.busy, bus.gnt);
    end
    @(posedge clk); #1;
    for (int d = 0; d <= dly; d++) begin
      bus.req = NREQ'($urandom);
      bus.ops = (3*NREQ)'($urandom);
      bus.rsp_ready = (d == dly);
      @(negedge clk);
      if (d == 0) begin
        checks++;
        if (cyc - gcyc != 2) begin
          errors++; $display("FAIL latency: got %0d expected 2", cyc - gcyc);
        end
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1 || bus.gnt !== '0) begin
        errors++; $display("FAIL resp_flags: valid=%b busy=%b gnt=%b expected 1 1 0", bus.rsp_valid, bus.busy, bus.gnt);
      end
      checks++;
      if (bus.rsp_id !== IDW'(w) || bus.rsp_x !== x || bus.rsp_z !== (x == 3'b111)) begin
        errors++; $display("FAIL resp_data: id=%0d x=%b z=%b expected %0d %b %b",
                           bus.rsp_id, bus.rsp_x, bus.rsp_z, w, x, (x == 3'b111));
      end
      hs_cyc = cyc;
      @(posedge clk); #1;
    end
    bus.req = '0;
    bus.rsp_ready = 1'b0;
    if (exp_eval < 16'hFFFF) exp_eval++;
    if (x == 3'b111 && exp_true < 16'hFFFF) exp_true++;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== '0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.rsp_id !== '0 || bus.rsp_x !== '0 || bus.rsp_z !== 1'b0) begin
        errors++; $display("FAIL reset_idle: gnt=%b valid=%b busy=%b id=%0d x=%b z=%b expected all 0",
                           bus.gnt, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_x, bus.rsp_z);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_truth_table();
    for (int v = 0; v < 8; v++) begin
      do_txn(4'b0001, {9'($urandom), 3'(v)}, 0);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int prev;
    apply_reset();
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 12'hFFF, 0);
      checks++;
      if (last_gnt != exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, last_gnt, exp_order[i]);
      end
      if (prev >= 0) begin
        checks++;
        if (hs_cyc - prev != 3) begin
          errors++; $display("FAIL rr_spacing: got %0d expected 3", hs_cyc - prev);
        end
      end
      prev = hs_cyc;
    end
  endtask

  task automatic test_rotation_skip();
    do_txn(4'b0010, 12'($urandom), 0);
    checks++;
    if (last_gnt != 1) begin
      errors++; $display("FAIL skip_setup: got %0d expected 1", last_gnt);
    end
    do_txn(4'b1001, 12'($urandom), 1);
    checks++;
    if (last_gnt != 3) begin
      errors++; $display("FAIL skip_first: got %0d expected 3", last_gnt);
    end
    do_txn(4'b1001, 12'($urandom), 0);
    checks++;
    if (last_gnt != 0) begin
      errors++; $display("FAIL skip_wrap: got %0d expected 0", last_gnt);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] o;
    o = 12'($urandom);
    o[8:6] = 3'b110;
    do_txn(4'b0100, o, 5);
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0100;
    bus.ops = 12'($urandom);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++; $display("FAIL mid_gnt: got %b expected 0100", bus.gnt);
    end
    @(posedge clk); #1;
    bus.req = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.rsp_id !== '0 || bus.rsp_x !== '0 || bus.rsp_z !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: gnt=%b valid=%b busy=%b id=%0d x=%b z=%b expected all 0",
                         bus.gnt, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_x, bus.rsp_z);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = NREQ - 1;
    exp_eval = 0;
    exp_true = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL mid_no_rsp: valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    do_txn(4'b0101, 12'($urandom), 0);
    checks++;
    if (last_gnt != 0) begin
      errors++; $display("FAIL mid_next_gnt: got %0d expected 0", last_gnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_txn(NREQ'($urandom), 12'($urandom), $urandom_range(0, 3));
    end
  endtask

`ifdef AND3_RR_SCHED_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_txn(4'b0001, (i % 3 == 0 && i < 9) ? 12'h007 : 12'h003, 0);
    end
    checks++;
    if (cnt_eval !== 16'(exp_eval) || cnt_eval !== 16'd10) begin
      errors++; $display("FAIL cnt_eval: got %0d expected 10", cnt_eval);
    end
    checks++;
    if (cnt_true !== 16'(exp_true) || cnt_true !== 16'd3) begin
      errors++; $display("FAIL cnt_true: got %0d expected 3", cnt_true);
    end
    dut.cnt_eval_q = 16'hFFFE;
    dut.cnt_true_q = 16'hFFFE;
    exp_eval = 16'hFFFE;
    exp_true = 16'hFFFE;
    for (int i = 0; i < 3; i++) do_txn(4'b0001, 12'h007, 0);
    checks++;
    if (cnt_eval !== 16'hFFFF || cnt_true !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_sat: got %h %h expected ffff ffff", cnt_eval, cnt_true);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_round_robin();
    test_rotation_skip();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef AND3_RR_SCHED_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/and3_rr_sched.md
Name: and3_rr_sched

Overview:
- Round-robin scheduler that shares one registered 3-input AND evaluator (Z = X1 & X2 & X3) among NREQ requesters.
- Each requester presents a request and a 3-bit operand.
  - The scheduler grants one requester and captures its operand.
  - It evaluates the operand and returns the result with the requester ID over a valid/ready response channel.
- Sits between multiple logic-test clients and the single shared gate datapath.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, 2, width of requester ID; must equal clog2(NREQ)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  req[i]=1: requester i has a pending operand
ops  input  3*NREQ  operand of requester i: ops[3i]=X1, ops[3i+1]=X2, ops[3i+2]=X3
gnt  output  NREQ  one-hot grant; operand of granted requester captured at this edge
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_id  output  IDW  ID of the requester whose result is presented
rsp_x  output  3  captured operand {X3,X2,X1}
rsp_z  output  1  AND result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; gnt=0; rsp_valid=0; rsp_id=0; rsp_x=0; rsp_z=0; busy=0.
  - Internal: op_reg=0, last_id=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - gnt is combinational.
  - Search req starting at (last_id+1) mod NREQ and wrap; the first set bit is the winner.
  - gnt = one-hot(winner) if any req, else 0.
  - On the edge with any req: op_reg <= ops[winner], id_reg <= winner, last_id <= winner, state <= EVAL.
- EVAL (exactly 1 cycle):
  - z_reg <= &op_reg; state <= RESP; gnt=0.
- RESP:
  - rsp_valid=1; rsp_id, rsp_x, rsp_z held stable while rsp_ready=0.
  - On the edge with rsp_ready=1: state <= IDLE, rsp_valid falls next cycle.
- Outputs rsp_id, rsp_x, rsp_z are registered. Outside RESP they hold their last values, and rsp_valid=0.
- Latency and throughput:
  - Grant edge to rsp_valid high is 2 cycles.
  - Minimum 3 cycles per transaction (IDLE, EVAL, RESP with rsp_ready=1).
- Requester protocol:
  - Requester keeps req and ops stable until it samples gnt[i]=1 at a clock edge, then may drop req.
  - A req still high after its grant is treated as a new request.
- Boundary conditions:
  - No req in IDLE: stay in IDLE, gnt=0, no pointer update.
  - Req deasserted before grant: no memory of it.
  - Simultaneous requests: strict rotation, winner is the nearest index after last_id. No requester waits more than NREQ-1 grants.
  - Wrap-around: last_id=NREQ-1 searches from 0.
  - ops/req changes during EVAL/RESP: ignored (op_reg is isolated).
  - rsp_ready high outside RESP: ignored.
  - Reset mid-transaction: transaction discarded, no response, pointer returns to NREQ-1.
- Width rules: winner index is zero-extended/truncated to IDW; NREQ not a power of 2 never produces an ID >= NREQ.

Optional Feature:
- Macro AND3_RR_SCHED_STATS_EN.
- When defined:
  - Adds output ports cnt_eval [15:0] and cnt_true [15:0], both reset to 0.
  - cnt_eval increments on every response handshake (RESP and rsp_ready).
  - cnt_true increments on the same handshake when rsp_z=1.
  - Both saturate at 16'hFFFF (no wrap).
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Exhaustive truth table:
  - Stimulus: requester 0 only, ops[2:0] = 000..111 in turn, rsp_ready=1.
  - Required: rsp_z=1 only for 111; rsp_id=0; rsp_x echoes the operand; rsp_valid exactly 2 cycles after the gnt edge.
- Round-robin order:
  - Stimulus: NREQ=4, req=4'b1111 held (each requester re-requests), operands all 111.
  - Required: grant order 0,1,2,3,0; rsp_id sequence matches; one response every 3 cycles.
- Rotation skip:
  - Stimulus: last grant 1, req=4'b1001.
  - Required: grant 3, then 0 on the next transaction.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in RESP with rsp_x=110, while ops of other requesters toggle.
  - Required: rsp_valid, rsp_id, rsp_x=110, rsp_z=0 stable; gnt=0 throughout; release on rsp_ready=1.
- Reset mid-operation:
  - Stimulus: rst_n low during EVAL after granting requester 2.
  - Required: all outputs 0 immediately; no response ever issued; the next grant with req=4'b0101 goes to 0.
- With AND3_RR_SCHED_STATS_EN:
  - Stimulus: 10 transactions, 3 with operand 111.
  - Required: cnt_eval=10, cnt_true=3; a preload/long run shows saturation at 16'hFFFF.
